// File: rtl/sseg_pkg.sv
// Shared seven-segment constants: active-low glyph table, blank/off patterns and anode select helper.
package sseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Active-low {g,f,e,d,c,b,a}; entry [n] is the glyph for hex digit n (b and d lower case).
    localparam logic [15:0][6:0] SEG_GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    function automatic logic [3:0] an_for_digit(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seven_seg_hex.sv
// Hex nibble to active-low seven-segment glyph decoder.
module seven_seg_hex
    import sseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_GLYPH[nibble];

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment scanner with tear-free frame-boundary updates and per-slot blanking.
// Optional build macro SSEG_LEADING_ZERO_BLANK_EN suppresses leading-zero digits (digit 0 always lit).
module seven_seg_scan
    import sseg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] value,
    input  logic [3:0]  dp_mask,
    input  logic        load,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [PW-1:0] prescaler;
    logic [1:0]    index;
    logic          tick;
    logic          frame_end;
    logic          blanking;
    logic          digit_lit;

    logic [15:0]   pending_value;
    logic [3:0]    pending_dp;
    logic [15:0]   display_value;
    logic [3:0]    display_dp;

    logic [3:0]    cur_nibble;
    logic [6:0]    glyph;
    logic [6:0]    seg_next;
    logic [3:0]    an_next;
    logic          dp_next;

    assign tick      = (prescaler == PW'(REFRESH_DIV - 1));
    assign frame_end = tick && (index == 2'd3);
    assign blanking  = (prescaler < PW'(BLANK_CYCLES));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
            index     <= '0;
        end else begin
            if (tick) begin
                prescaler <= '0;
                index     <= index + 2'd1;
            end else begin
                prescaler <= prescaler + PW'(1);
            end
        end
    end

    // A load landing on the frame boundary bypasses pending so it is shown in the very next frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_value <= '0;
            pending_dp    <= '0;
            display_value <= '0;
            display_dp    <= '0;
        end else begin
            if (load) begin
                pending_value <= value;
                pending_dp    <= dp_mask;
            end
            if (frame_end) begin
                display_value <= load ? value   : pending_value;
                display_dp    <= load ? dp_mask : pending_dp;
            end
        end
    end

    assign cur_nibble = display_value[{index, 2'b00} +: 4];

    seven_seg_hex u_hex (
        .nibble (cur_nibble),
        .seg    (glyph)
    );

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    // upper_nz[i]: nibble i or any higher nibble is non-zero; digit 0 is forced lit.
    logic [3:0] upper_nz;

    always_comb begin
        upper_nz    = '0;
        upper_nz[3] = |display_value[15:12];
        upper_nz[2] = upper_nz[3] | (|display_value[11:8]);
        upper_nz[1] = upper_nz[2] | (|display_value[7:4]);
        upper_nz[0] = 1'b1;
        digit_lit   = upper_nz[index] | display_dp[index];
    end
`else
    assign digit_lit = 1'b1;
`endif

    always_comb begin
        an_next  = AN_OFF;
        seg_next = SEG_BLANK;
        dp_next  = 1'b1;
        if (!blanking && digit_lit) begin
            an_next  = an_for_digit(index);
            seg_next = glyph;
            dp_next  = ~display_dp[index];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan (REFRESH_DIV=8, BLANK_CYCLES=2); honours SSEG_LEADING_ZERO_BLANK_EN.
module tb_seven_seg_scan;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_mask = '0;
    logic        load = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;

    int          checks = 0;
    int          errors = 0;
    int unsigned n = 0;
    logic        watch_a = 1'b0;
    logic        saw_a = 1'b0;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } slot_t;

    typedef struct {
        logic [15:0]     value;
        logic [3:0]      dp_mask;
        logic [3:0][6:0] seg;
        logic [3:0]      dp_n;
        logic [3:0]      lit_lzb;
    } vec_t;

    slot_t sb[$];
    vec_t  vecs[6];

    seven_seg_scan #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .value   (value),
        .dp_mask (dp_mask),
        .load    (load),
        .seg     (seg),
        .an      (an),
        .dp      (dp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock; n counts edges since reset release, so n%32 is the scan state before the next edge.
    task automatic step();
        @(posedge clk);
        n++;
        @(negedge clk);
        if (watch_a && an !== 4'hF && seg === 7'h08) saw_a = 1'b1;
    endtask

    task automatic wait_state(input int unsigned p);
        for (int i = 0; i < 64; i++) begin
            if (n % 32 == p) return;
            step();
        end
        check("wait_state", n % 32, p);
    endtask

    task automatic lit_start();
        for (int i = 0; i < 40 && an !== 4'hF; i++) step();
        for (int i = 0; i < 40 && an === 4'hF; i++) step();
        check("lit_found", (an !== 4'hF), 1);
    endtask

    task automatic check_slot(input slot_t e, input string tag);
        logic [3:0] start_an;
        int         len;
        lit_start();
        check({tag, "_an"}, an, e.an);
        check({tag, "_seg"}, seg, e.seg);
        check({tag, "_dp"}, dp, e.dp);
        start_an = an;
        len = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (an === start_an) len++;
            else break;
        end
        check({tag, "_len"}, len, 6);
    endtask

    task automatic drain(input string tag);
        slot_t e;
        int    k;
        k = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_slot(e, $sformatf("%s_d%0d", tag, k));
            k++;
        end
    endtask

    task automatic push_slot(input int d, input logic [6:0] s, input logic dpn);
        slot_t e;
        e.an  = ~(4'b0001 << d);
        e.seg = s;
        e.dp  = dpn;
        sb.push_back(e);
    endtask

    task automatic load_word(input logic [15:0] v, input logic [3:0] m);
        value   = v;
        dp_mask = m;
        load    = 1'b1;
        step();
        load    = 1'b0;
    endtask

    initial begin
        int cnt;

        vecs[0] = '{16'h1234, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111, 4'b1111};
        vecs[1] = '{16'h0007, 4'b0100, {7'h40, 7'h40, 7'h40, 7'h78}, 4'b1011, 4'b0101};
        vecs[2] = '{16'h89AB, 4'b1010, {7'h00, 7'h10, 7'h08, 7'h03}, 4'b0101, 4'b1111};
        vecs[3] = '{16'h0C0D, 4'b0000, {7'h40, 7'h46, 7'h40, 7'h21}, 4'b1111, 4'b0111};
        vecs[4] = '{16'h0000, 4'b0000, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111, 4'b0001};
        vecs[5] = '{16'h6EF5, 4'b1111, {7'h02, 7'h06, 7'h0E, 7'h12}, 4'b0000, 4'b1111};

        repeat (2) @(negedge clk);
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1'b1);
        reset_n = 1'b1;
        n = 0;

        // Table: load mid-frame, expect the whole next frame to show it.
        for (int i = 0; i < 6; i++) begin
            wait_state(10);
            load_word(vecs[i].value, vecs[i].dp_mask);
            for (int d = 0; d < 4; d++) begin
`ifdef SSEG_LEADING_ZERO_BLANK_EN
                if (vecs[i].lit_lzb[d]) push_slot(d, vecs[i].seg[d], vecs[i].dp_n[d]);
`else
                push_slot(d, vecs[i].seg[d], vecs[i].dp_n[d]);
`endif
            end
            wait_state(0);
            drain($sformatf("vec%0d", i));
        end

        // Two loads in one frame: only the last ever reaches the display.
        wait_state(5);
        saw_a   = 1'b0;
        watch_a = 1'b1;
        load_word(16'hAAAA, 4'b0000);
        wait_state(20);
        load_word(16'h5555, 4'b0000);
        for (int d = 0; d < 4; d++) push_slot(d, 7'h12, 1'b1);
        wait_state(0);
        drain("last_load");
        watch_a = 1'b0;
        check("no_A_glyph", saw_a, 1'b0);

        // Load on the boundary cycle overrides an older pending value.
        wait_state(10);
        load_word(16'h1111, 4'b0000);
        wait_state(31);
        load_word(16'hBEEF, 4'b0000);
        push_slot(0, 7'h0E, 1'b1);
        push_slot(1, 7'h06, 1'b1);
        push_slot(2, 7'h06, 1'b1);
        push_slot(3, 7'h03, 1'b1);
        drain("boundary");

        // Reset mid-slot of digit 2 with a load still pending.
        wait_state(10);
        load_word(16'h3333, 4'b0000);
        for (int d = 0; d < 4; d++) push_slot(d, 7'h30, 1'b1);
        wait_state(0);
        drain("pre_rst");
        wait_state(10);
        load_word(16'h2222, 4'b0000);
        wait_state(21);
        check("mid_digit2_an", an, 4'b1011);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_an", an, 4'hF);
        check("async_rst_seg", seg, 7'h7F);
        check("async_rst_dp", dp, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            cnt++;
            if (an !== 4'hF) break;
        end
        check("rel_latency", cnt, 3);
        check("rel_an", an, 4'b1110);
        check("rel_seg", seg, 7'h40);
        check("rel_dp", dp, 1'b1);
        push_slot(0, 7'h40, 1'b1);
        wait_state(0);
        drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000: clk cycles per digit slot (1 kHz slot, 250 Hz frame at 100 MHz); legal range 4..2^20.
REQ-002 SHALL have parameter BLANK_CYCLES, default 1000: cycles at the start of each slot with all anodes off (anti-ghosting); legal range 1..REFRESH_DIV-2.
REQ-003 SHALL have port clk  input  1  system clock, single clock domain.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port value  input  16  four hex nibbles; [3:0] = rightmost digit (digit 0).
REQ-006 SHALL have port dp_mask  input  4  per-digit decimal point request, active-high, bit i = digit i.
REQ-007 SHALL have port load  input  1  single-cycle strobe capturing value/dp_mask.
REQ-008 SHALL have port seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-009 SHALL have port an  output  4  active-low anode enables, bit i = digit i.
REQ-010 SHALL have port dp  output  1  active-low decimal point.

Function
REQ-011 SHALL keep a prescaler counting 0..REFRESH_DIV-1, wrapping to 0; tick = prescaler at REFRESH_DIV-1.
REQ-012 SHALL keep a 2-bit digit index incremented on tick, wrapping 3->0; frame boundary = tick with index 3.
REQ-013 SHALL capture value/dp_mask into a pending register on load; pending copied to display register only at frame boundary (tear-free).
REQ-014 SHALL, when load coincides with frame boundary, transfer the newly loaded value directly into the display register.
REQ-015 SHALL, when several loads occur within one frame, display only the last.
REQ-016 SHALL blank (an=4'b1111, seg=7'h7F, dp=1) whenever prescaler < BLANK_CYCLES.
REQ-017 SHALL otherwise drive an with only bit[index] low, seg = hex glyph of display nibble[index], dp = ~display_dp[index].
REQ-018 SHALL register seg/an/dp: outputs reflect prescaler/index/display state of the previous cycle (latency 1).
REQ-019 SHALL use standard hex glyphs 0-F (b and d lower case); glyphs identical to existing seven_seg_hex decoder.

Reset
REQ-020 SHALL on reset_n low, immediately and asynchronously: prescaler=0, index=0, pending=0, display=0, dp regs=0, an=4'b1111, seg=7'h7F, dp=1.
REQ-021 SHALL, when reset asserts mid-frame, discard any pending load; first lit slot after release is digit 0 after BLANK_CYCLES+1 cycles.

Configuration
REQ-022 SHALL, with SSEG_LEADING_ZERO_BLANK_EN defined, keep an all-high for any digit i>0 whose nibble and all higher nibbles are zero and whose dp bit is clear; digit 0 always lit.
REQ-023 SHALL, without SSEG_LEADING_ZERO_BLANK_EN, light all four digits every frame including leading zeros.

Structure
REQ-024 SHALL take glyph table constants, SEG_BLANK (7'h7F) and AN_OFF (4'b1111) from shared package sseg_pkg.
REQ-025 SHALL instantiate seven_seg_hex as the single sub-module for nibble-to-segment decoding; no other sub-modules.

Verification (bench uses REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-026 SHALL cover: reset release, load value=16'h1234 -> after boundary, slots show an=1110/seg '4', 1101/'3', 1011/'2', 0111/'1', each lit 6 cycles after 2 blank cycles.
REQ-027 SHALL cover: load 16'hAAAA mid-frame then 16'h5555 before boundary -> no 'A' glyph ever displayed; next frame all '5'.
REQ-028 SHALL cover: load 16'hBEEF exactly on frame-boundary cycle -> following frame shows F,E,E,B.
REQ-029 SHALL cover: value=16'h0007, dp_mask=4'b0100 -> with macro digit 3 an stays high, digit 2 shows '0' with dp=0; without macro all four lit.
REQ-030 SHALL cover: reset_n pulsed low mid-slot of digit 2 -> same cycle an=1111, seg=7F, dp=1; pending discarded; digit 0 shows '0' after release.
